// File: rtl/sprite_anim_renderer_pkg.sv
// Shared definitions for the sprite renderers: animation mode codes,
// transparent colour, per-sprite geometry and the game state codes that
// the game controller maps onto anim_mode.
package sprite_anim_renderer_pkg;

  // Animation mode codes carried on anim_mode
  typedef enum logic [1:0] {
    ANIM_IDLE   = 2'd0,
    ANIM_RUN    = 2'd1,
    ANIM_FREEZE = 2'd2,
    ANIM_DEAD   = 2'd3
  } anim_mode_e;

  // Colour 0 is never drawn by the compositor
  localparam logic [2:0] TRANSPARENT = 3'd0;

  // Sprite geometry (pixels)
  localparam int DINO_W   = 10;
  localparam int DINO_H   = 12;
  localparam int BIRD_W   = 12;
  localparam int BIRD_H   = 8;
  localparam int CACTUS_W = 6;
  localparam int CACTUS_H = 12;

  // Game states as seen by the renderers
  typedef enum logic [1:0] {
    GAME_ATTRACT = 2'd0,
    GAME_PLAY    = 2'd1,
    GAME_PAUSE   = 2'd2,
    GAME_OVER    = 2'd3
  } game_state_e;

  // Animation mode each game state should drive
  function automatic anim_mode_e game_anim_mode(input game_state_e gs);
    case (gs)
      GAME_PLAY:  return ANIM_RUN;
      GAME_PAUSE: return ANIM_FREEZE;
      GAME_OVER:  return ANIM_DEAD;
      default:    return ANIM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sprite_anim_renderer_seq.sv
// Animation frame sequencer: frameClk rising-edge detect, tick divider and
// the frame-selection state machine. frame_idx is the machine's state.
module anim_frame_sequencer
  import sprite_anim_renderer_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int RUN_FIRST  = 1,
  parameter int RUN_LAST   = 2,
  parameter int DEAD_FRAME = 3,
  parameter int DIVIDE     = 4,
  localparam int FI_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            frameClk,
  input  logic [1:0]      anim_mode,
  output logic [FI_W-1:0] frame_idx
);

  localparam int DIV_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIVIDE - 1);

  logic            frame_clk_q, frame_clk_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [FI_W-1:0] frame_q, frame_d;
  logic            tick, step;

  // State register; edge detector resets high so a high frameClk out of reset is not a tick
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_clk_q <= 1'b1;
      div_q       <= DIV_RELOAD;
      frame_q     <= '0;
    end else begin
      frame_clk_q <= frame_clk_d;
      div_q       <= div_d;
      frame_q     <= frame_d;
    end
  end

  // Next state: one tick per frameClk rising edge, one step per DIVIDE ticks
  always_comb begin
    tick        = frameClk & ~frame_clk_q;
    step        = tick && (div_q == '0);
    frame_clk_d = frameClk;
    div_d       = div_q;
    frame_d     = frame_q;
    if (tick) div_d = step ? DIV_RELOAD : (div_q - DIV_W'(1));
    if (step) begin
      unique case (anim_mode_e'(anim_mode))
        ANIM_IDLE:   frame_d = '0;
        ANIM_RUN: begin
          if ((frame_q < FI_W'(RUN_FIRST)) || (frame_q >= FI_W'(RUN_LAST)))
            frame_d = FI_W'(RUN_FIRST);
          else
            frame_d = frame_q + FI_W'(1);
        end
        ANIM_FREEZE: frame_d = frame_q;
        ANIM_DEAD:   frame_d = FI_W'(DEAD_FRAME);
        default:     frame_d = frame_q;
      endcase
    end
  end

  // Output: current frame straight from the state register
  always_comb begin
    frame_idx = frame_q;
  end

endmodule

// File: rtl/sprite_anim_renderer.sv
// Sprite renderer: hit test and ROM address for the current scan pixel,
// registered address stage, then a ROM_LAT-deep hit/valid delay so the
// colour returned by the ROM lines up with its qualifiers.
module sprite_anim_renderer
  import sprite_anim_renderer_pkg::*;
#(
  parameter int COORD_W    = 8,
  parameter int SPR_W      = 10,
  parameter int SPR_H      = 12,
  parameter int NUM_FRAMES = 4,
  parameter int RUN_FIRST  = 1,
  parameter int RUN_LAST   = 2,
  parameter int DEAD_FRAME = 3,
  parameter int DIVIDE     = 4,
  parameter int ADDR_W     = 9,
  parameter int COLOR_W    = 3,
  parameter int ROM_LAT    = 1,
  localparam int FI_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frameClk,
  input  logic [1:0]         anim_mode,
  input  logic [COORD_W-1:0] spr_x,
  input  logic [COORD_W-1:0] spr_y,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               pix_valid,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_q,
  output logic               out_valid,
  output logic               out_hit,
  output logic [COLOR_W-1:0] out_color,
  output logic [FI_W-1:0]    frame_idx
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0]    SPR_W_C  = CW1'(SPR_W);
  localparam logic [CW1-1:0]    SPR_H_C  = CW1'(SPR_H);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(SPR_W);

  logic [CW1-1:0]     x_end, y_end;
  logic [COORD_W-1:0] dx, dy;
  logic               hit0;
  logic [ADDR_W-1:0]  addr0;

  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               hit_s1_q, hit_s1_d;
  logic               valid_s1_q, valid_s1_d;
  logic [ROM_LAT-1:0] hit_sr_q, hit_sr_d;
  logic [ROM_LAT-1:0] valid_sr_q, valid_sr_d;

  anim_frame_sequencer #(
    .NUM_FRAMES (NUM_FRAMES),
    .RUN_FIRST  (RUN_FIRST),
    .RUN_LAST   (RUN_LAST),
    .DEAD_FRAME (DEAD_FRAME),
    .DIVIDE     (DIVIDE)
  ) u_seq (
    .clk       (clk),
    .resetn    (resetn),
    .frameClk  (frameClk),
    .anim_mode (anim_mode),
    .frame_idx (frame_idx)
  );

  // Stage 0: box test with one extra bit so right/bottom overhang clips instead of wrapping
  always_comb begin
    x_end = {1'b0, spr_x} + SPR_W_C;
    y_end = {1'b0, spr_y} + SPR_H_C;
    dx    = pix_x - spr_x;
    dy    = pix_y - spr_y;
    hit0  = pix_valid && (pix_x >= spr_x) && ({1'b0, pix_x} < x_end)
                      && (pix_y >= spr_y) && ({1'b0, pix_y} < y_end);
    addr0 = ADDR_W'(frame_idx) * FRAME_SZ + ADDR_W'(dy) * ROW_SZ + ADDR_W'(dx);
  end

  // Next pipeline contents; address only moves on a hit to keep the ROM bus quiet
  always_comb begin
    rom_addr_d    = hit0 ? addr0 : rom_addr_q;
    hit_s1_d      = hit0;
    valid_s1_d    = pix_valid;
    hit_sr_d      = hit_sr_q;
    valid_sr_d    = valid_sr_q;
    hit_sr_d[0]   = hit_s1_q;
    valid_sr_d[0] = valid_s1_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      hit_sr_d[i]   = hit_sr_q[i-1];
      valid_sr_d[i] = valid_sr_q[i-1];
    end
  end

  // Pipeline registers; reset flushes every in-flight pixel
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rom_addr_q <= '0;
      hit_s1_q   <= 1'b0;
      valid_s1_q <= 1'b0;
      hit_sr_q   <= '0;
      valid_sr_q <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit_s1_q   <= hit_s1_d;
      valid_s1_q <= valid_s1_d;
      hit_sr_q   <= hit_sr_d;
      valid_sr_q <= valid_sr_d;
    end
  end

  // Outputs: colour forced transparent outside the sprite box
  always_comb begin
    rom_addr  = rom_addr_q;
    out_valid = valid_sr_q[ROM_LAT-1];
    out_hit   = hit_sr_q[ROM_LAT-1];
    out_color = out_hit ? rom_q : COLOR_W'(TRANSPARENT);
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: two instances (ROM latency 1 and 3) share
// stimulus; a behavioural model predicts frame, ROM address and outputs.
module tb_sprite_anim_renderer;

  localparam int SPR_W = 10;
  localparam int SPR_H = 12;
  localparam int RUN_FIRST = 1;
  localparam int RUN_LAST = 2;
  localparam int DEAD_FRAME = 3;
  localparam int DIVIDE = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, frameClk, pix_valid;
  logic [1:0] anim_mode;
  logic [7:0] spr_x, spr_y, pix_x, pix_y;

  logic [8:0] rom_addr_a, rom_addr_b;
  logic [2:0] rom_q_a, rom_q_b, out_color_a, out_color_b;
  logic       out_valid_a, out_valid_b, out_hit_a, out_hit_b;
  logic [1:0] frame_idx_a, frame_idx_b;
  logic [2:0] rom_pipe_b [0:2];

  sprite_anim_renderer #(
    .COORD_W(8), .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(4), .RUN_FIRST(RUN_FIRST),
    .RUN_LAST(RUN_LAST), .DEAD_FRAME(DEAD_FRAME), .DIVIDE(DIVIDE), .ADDR_W(9),
    .COLOR_W(3), .ROM_LAT(1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .frameClk(frameClk), .anim_mode(anim_mode),
    .spr_x(spr_x), .spr_y(spr_y), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .rom_addr(rom_addr_a), .rom_q(rom_q_a), .out_valid(out_valid_a), .out_hit(out_hit_a),
    .out_color(out_color_a), .frame_idx(frame_idx_a)
  );

  sprite_anim_renderer #(
    .COORD_W(8), .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(4), .RUN_FIRST(RUN_FIRST),
    .RUN_LAST(RUN_LAST), .DEAD_FRAME(DEAD_FRAME), .DIVIDE(DIVIDE), .ADDR_W(9),
    .COLOR_W(3), .ROM_LAT(3)
  ) dut_b (
    .clk(clk), .resetn(resetn), .frameClk(frameClk), .anim_mode(anim_mode),
    .spr_x(spr_x), .spr_y(spr_y), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .rom_addr(rom_addr_b), .rom_q(rom_q_b), .out_valid(out_valid_b), .out_hit(out_hit_b),
    .out_color(out_color_b), .frame_idx(frame_idx_b)
  );

  function automatic logic [2:0] rom_fn(input logic [8:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6];
  endfunction

  // ROM models with 1 and 3 cycles of read latency
  always @(posedge clk) rom_q_a <= rom_fn(rom_addr_a);
  always @(posedge clk) begin
    rom_pipe_b[0] <= rom_fn(rom_addr_b);
    rom_pipe_b[1] <= rom_pipe_b[0];
    rom_pipe_b[2] <= rom_pipe_b[1];
  end
  assign rom_q_b = rom_pipe_b[2];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame from tick counting, expected outputs by pixel age
  int   m_frame, m_ticks, m_addr;
  bit   m_fclk_prev, m_live = 0;
  logic [4:0] exp_q[$];   // {valid, hit, colour}, index = cycles since capture

  function automatic int next_frame(input int f, input int mode);
    case (mode)
      0: return 0;
      1: return (f < RUN_FIRST || f >= RUN_LAST) ? RUN_FIRST : f + 1;
      2: return f;
      default: return DEAD_FRAME;
    endcase
  endfunction

  always @(posedge clk) begin
    int px, py, sx, sy, addr;
    bit hit;
    logic [8:0] av;
    if (!resetn) begin
      m_frame = 0; m_ticks = 0; m_fclk_prev = 1; m_addr = 0; m_live = 1;
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(5'd0);
    end else if (m_live) begin
      px = pix_x; py = pix_y; sx = spr_x; sy = spr_y;
      hit = pix_valid && px >= sx && px < sx + SPR_W && py >= sy && py < sy + SPR_H;
      addr = m_frame * SPR_W * SPR_H + (py - sy) * SPR_W + (px - sx);
      av = addr[8:0];
      if (hit) m_addr = addr;
      exp_q.push_front({pix_valid, hit, hit ? rom_fn(av) : 3'd0});
      void'(exp_q.pop_back());
      if (frameClk && !m_fclk_prev) begin
        m_ticks++;
        if (m_ticks % DIVIDE == 0) m_frame = next_frame(m_frame, anim_mode);
      end
      m_fclk_prev = frameClk;
    end
  end

  // Compare process: every cycle once the model has seen reset
  always @(negedge clk) begin
    logic [4:0] e1, e3;
    if (m_live) begin
      e1 = exp_q[1];
      e3 = exp_q[3];
      check("frame_a", frame_idx_a, m_frame);
      check("frame_b", frame_idx_b, m_frame);
      check("addr_a", rom_addr_a, m_addr);
      check("addr_b", rom_addr_b, m_addr);
      check("valid_a", out_valid_a, e1[4]);
      check("hit_a", out_hit_a, e1[3]);
      check("color_a", out_color_a, e1[2:0]);
      check("valid_b", out_valid_b, e3[4]);
      check("hit_b", out_hit_b, e3[3]);
      check("color_b", out_color_b, e3[2:0]);
    end
  end

  // Hit counter for the directed scan
  bit scan_on = 0;
  int hit_cnt_a = 0;
  always @(negedge clk) if (scan_on && out_hit_a) hit_cnt_a++;

  // Driver tasks
  bit rand_pix = 0;

  task automatic rand_pixel();
    pix_valid = ($urandom_range(0, 3) != 0);
    pix_x = 8'(int'(spr_x) + int'($urandom_range(0, 13)) - 2);
    pix_y = 8'(int'(spr_y) + int'($urandom_range(0, 15)) - 2);
  endtask

  task automatic cyc(input logic fclk);
    @(posedge clk);
    #2;
    frameClk = fclk;
    if (rand_pix) rand_pixel();
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) cyc(1'b1);
    repeat (lo) cyc(1'b0);
  endtask

  initial begin
    resetn = 1'b0; frameClk = 1'b1; anim_mode = 2'd1;
    spr_x = 8'd0; spr_y = 8'd0; pix_x = 8'd0; pix_y = 8'd0; pix_valid = 1'b0;

    // Reset with frameClk already high, then hold it high: no tick
    repeat (2) cyc(1'b1);
    resetn = 1'b1;
    check("rst_frame", frame_idx_a, 0);
    check("rst_addr", rom_addr_a, 0);
    check("rst_valid", out_valid_b, 0);
    repeat (20) cyc(1'b1);
    repeat (2) cyc(1'b0);
    check("hi_no_tick", frame_idx_a, 0);

    // RUN: step every 4th pulse
    for (int p = 1; p <= 8; p++) begin
      pulse(2, 2);
      if (p == 3) check("run_p3", frame_idx_a, 0);
      if (p == 4) check("run_p4", frame_idx_a, 1);
      if (p == 7) check("run_p7", frame_idx_a, 1);
      if (p == 8) check("run_p8", frame_idx_a, 2);
    end
    pulse(20, 3);
    pulse(2, 2);
    pulse(2, 2);
    check("run_p11", frame_idx_a, 2);
    pulse(2, 2);
    check("run_p12", frame_idx_a, 1);

    // DEAD takes effect only at the next step
    anim_mode = 2'd3;
    repeat (3) pulse(2, 2);
    check("dead_wait", frame_idx_a, 1);
    pulse(2, 2);
    check("dead_step", frame_idx_a, 3);

    // IDLE back to 0, then RUN from outside the loop enters at RUN_FIRST
    anim_mode = 2'd0;
    repeat (4) pulse(2, 2);
    check("idle", frame_idx_a, 0);
    anim_mode = 2'd1;
    repeat (4) pulse(2, 2);
    check("run_enter", frame_idx_a, 1);

    // Directed scan across row 2 of the sprite at (20,50), frame 1
    spr_x = 8'd20; spr_y = 8'd50; pix_y = 8'd52;
    hit_cnt_a = 0;
    scan_on = 1;
    for (int x = 18; x <= 33; x++) begin
      cyc(1'b0);
      if (x - 1 >= 20 && x - 1 <= 29) check("scan_addr", rom_addr_a, 140 + (x - 1 - 20));
      else if (x - 1 > 29) check("scan_hold", rom_addr_a, 149);
      pix_valid = (x <= 31);
      pix_x = 8'(x);
    end
    pix_valid = 1'b0;
    repeat (6) cyc(1'b0);
    scan_on = 0;
    check("scan_hits", hit_cnt_a, 10);

    // Right-edge overhang clips, no wrap to column 0
    spr_x = 8'd250; spr_y = 8'd50; pix_y = 8'd50;
    pix_valid = 1'b1; pix_x = 8'd4;
    cyc(1'b0);
    check("nowrap_hold", rom_addr_a, 149);
    pix_x = 8'd255;
    cyc(1'b0);
    check("edge_addr", rom_addr_a, 125);
    pix_valid = 1'b0;
    repeat (5) cyc(1'b0);

    // Randomized traffic, modes, positions and occasional resets
    rand_pix = 1;
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 2) == 0);
      resetn = ($urandom_range(0, 299) != 0);
      if (i % 64 == 0) begin
        spr_x = 8'($urandom);
        spr_y = 8'($urandom);
        anim_mode = 2'($urandom_range(0, 3));
      end
    end
    rand_pix = 0;
    resetn = 1'b1;

    // FREEZE at frame 2, then a one-cycle reset mid-scan
    resetn = 1'b0;
    cyc(1'b0);
    resetn = 1'b1;
    anim_mode = 2'd1;
    repeat (8) pulse(2, 2);
    check("frz_pre", frame_idx_a, 2);
    anim_mode = 2'd2;
    repeat (4) pulse(2, 2);
    check("frz_hold", frame_idx_a, 2);
    spr_x = 8'd100; spr_y = 8'd100;
    rand_pix = 1;
    repeat (10) cyc(1'b0);
    rand_pix = 0;
    pix_valid = 1'b1; pix_x = 8'd103; pix_y = 8'd104;
    resetn = 1'b0;
    cyc(1'b0);
    resetn = 1'b1;
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      if (j == 0) check("mid_rst_frame", frame_idx_a, 0);
      if (j <= 1) check("mid_rst_valid_a", out_valid_a, 0);
      check("mid_rst_valid_b", out_valid_b, 0);
    end
    pix_valid = 1'b0;
    repeat (6) cyc(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
- Parametrised successor to the fixed dino sprite renderer/controller pair.
- Animates any fixed-size sprite stored as consecutive frames in an external sprite ROM.
- Generates the ROM address for the current scan pixel and returns a colour plus hit flag, aligned through a ROM-latency-matched pipeline.
- Sits between the VGA scan counters and the layer compositor; one instance per sprite (dino, bird, cactus).

Parameters:
COORD_W, 8, width of x/y/sprite-position coordinates
SPR_W, 10, sprite width in pixels
SPR_H, 12, sprite height in pixels
NUM_FRAMES, 4, frames stored in ROM; frame f base address = f*SPR_W*SPR_H
RUN_FIRST, 1, first frame of run loop
RUN_LAST, 2, last frame of run loop (RUN_FIRST <= RUN_LAST < NUM_FRAMES)
DEAD_FRAME, 3, frame shown in dead mode
DIVIDE, 4, frameClk rising edges per animation step (>=1)
ADDR_W, 9, ROM address width; must hold NUM_FRAMES*SPR_W*SPR_H-1
COLOR_W, 3, ROM data / colour width
ROM_LAT, 1, ROM read latency in clk cycles (>=1)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
frameClk  in  1  frame-rate level signal, synchronous to clk
anim_mode  in  2  0 IDLE, 1 RUN, 2 FREEZE, 3 DEAD
spr_x  in  COORD_W  sprite left edge
spr_y  in  COORD_W  sprite top edge
pix_x  in  COORD_W  scan pixel x
pix_y  in  COORD_W  scan pixel y
pix_valid  in  1  scan pixel qualifier
rom_addr  out  ADDR_W  registered sprite ROM address
rom_q  in  COLOR_W  ROM data, ROM_LAT cycles after rom_addr
out_valid  out  1  pix_valid delayed by 1+ROM_LAT
out_hit  out  1  pixel lies inside sprite box, aligned with out_valid
out_color  out  COLOR_W  rom_q when out_hit, else 0
frame_idx  out  clog2(NUM_FRAMES)  current animation frame

Behaviour:
- Reset (resetn=0 at posedge clk): frame_idx=0, divider=DIVIDE-1, edge-detect register=1 (no spurious tick if frameClk is high out of reset), all pipeline stages cleared. rom_addr, out_valid, out_hit and out_color are all 0. Reset wins over every other event. Reset mid-operation flushes in-flight pixels.
- Tick: tick=frameClk & ~frameClk_q. Exactly one tick per rising edge, regardless of how long frameClk stays high.
- Divider: on tick, if divider==0 then step=1 and divider<=DIVIDE-1, else divider<=divider-1. DIVIDE=1 gives a step on every tick.
- anim_mode is sampled only on step cycles. Frame update on step:
  - IDLE -> frame 0.
  - RUN -> if frame_idx is outside [RUN_FIRST,RUN_LAST] or frame_idx==RUN_LAST, go to RUN_FIRST; else frame_idx+1.
  - FREEZE -> hold.
  - DEAD -> DEAD_FRAME.
- frame_idx is registered; the new value applies to pixels presented on the cycle after the step.
- Hit test (combinational, stage 0): pix_x>=spr_x, pix_x<spr_x+SPR_W, pix_y>=spr_y, pix_y<spr_y+SPR_H, with pix_valid=1. Sums are computed at COORD_W+1 bits, so a sprite that overhangs the right or bottom edge clips and does not wrap.
- Address: frame_idx*SPR_W*SPR_H + (pix_y-spr_y)*SPR_W + (pix_x-spr_x), at ADDR_W bits, no offset.
- On a miss, rom_addr is held at its previous value to save ROM toggling.
- Stage 1 registers rom_addr, hit and valid. hit and valid then pass through a ROM_LAT-deep shift register.
- out_color = hit_d ? rom_q : 0. Total latency pix_* -> out_* is 1+ROM_LAT cycles, full throughput, one pixel per clk.
- Colour 0 is transparent by convention; the compositor uses out_hit && out_color!=0.

Decomposition:
- Shared package/header holds: ANIM_IDLE/RUN/FREEZE/DEAD codes, TRANSPARENT colour value, sprite geometry constants for dino/bird/cactus, and the GAME_* state codes used to drive anim_mode.
- One natural sub-module: anim_frame_sequencer (edge detect, divider, frame FSM, frame_idx output). The hit/address pipeline stays in the top module.

Test Plan:
- Reset, then 8 frameClk pulses with anim_mode=RUN, DIVIDE=4, RUN 1..2 -> frame_idx steps 0->1 after the 4th pulse and 1->2 after the 8th; frameClk held high 20 cycles produces one tick only.
- RUN for 12 pulses, then DEAD -> frame_idx cycles 1,2,1; reaches 3 on the next step after the mode change, not before.
- spr_x=20, spr_y=50, frame 1, scan pix_x 18..31 at pix_y=52 -> out_hit=1 exactly for x 20..29; rom_addr=120+2*10+(x-20); out_* appears 2 cycles after input (ROM_LAT=1).
- spr_x=250, COORD_W=8, pix_x=4 -> out_hit=0 (no wrap); pix_x=255 -> hit, address column 5.
- ROM_LAT=3 build with a model ROM returning addr[2:0] -> out_color matches the address from 4 cycles earlier; out_valid follows a pix_valid gap pattern exactly.
- Assert resetn for 1 cycle mid-scan in FREEZE at frame 2 -> frame_idx=0 and all out_* low for the next 1+ROM_LAT cycles.
